stream_upsizer: RTL and testbench



---
 rtl/stream_pkg.sv | 11 +
 rtl/stream_upsizer.sv | 101 ++++++++++
 tb/tb_stream_upsizer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters.
package stream_pkg;

  localparam int unsigned MAX_RATIO = 16;

  // One-hot keep bit for lane cnt; callers truncate to their own lane count.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned cnt);
    lane_mask = MAX_RATIO'(1) << cnt;
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow DW-bit beats into one registered wide word; s_last flushes
// a partial word with m_keep marking the filled lanes.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int unsigned DW    = 10,
  parameter int unsigned RATIO = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                m_valid,
  output logic [DW*RATIO-1:0] m_data,
  output logic [RATIO-1:0]    m_keep,
  output logic                m_last,
  input  logic                m_ready
);

  localparam int unsigned CW = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 1 || RATIO > MAX_RATIO) begin : g_bad_ratio
    $error("stream_upsizer: RATIO out of range 1..16");
  end

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW*RATIO-1:0] acc_q, acc_d, acc_merged;
  logic [RATIO-1:0]    keep_q, keep_d, keep_merged, lane_we;
  logic                m_valid_q, m_valid_d;
  logic [DW*RATIO-1:0] m_data_q, m_data_d;
  logic [RATIO-1:0]    m_keep_q, m_keep_d;
  logic                m_last_q, m_last_d;

  logic acc_en, out_en, done;

  // Ready depends only on output occupancy and m_ready.
  assign s_ready = ~m_valid_q | m_ready;
  assign acc_en  = s_valid & s_ready;
  assign out_en  = m_valid_q & m_ready;
  assign done    = acc_en & ((cnt_q == CW'(RATIO - 1)) | s_last);

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign lane_we[k]                = acc_en & (cnt_q == CW'(k));
    assign acc_merged[k*DW +: DW]    = lane_we[k] ? s_data : acc_q[k*DW +: DW];
    assign keep_merged[k]            = keep_q[k] | lane_we[k];
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    keep_d    = keep_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    if (done) begin
      cnt_d     = '0;
      acc_d     = '0;
      keep_d    = '0;
      m_valid_d = 1'b1;
      m_data_d  = acc_merged;
      m_keep_d  = keep_q | RATIO'(lane_mask(32'(cnt_q)));
      m_last_d  = s_last;
    end else begin
      if (acc_en) begin
        cnt_d  = cnt_q + CW'(1);
        acc_d  = acc_merged;
        keep_d = keep_merged;
      end
      if (out_en) m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      keep_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      keep_q    <= keep_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed vector bench for stream_upsizer with DW=10, RATIO=4.
module tb_stream_upsizer;

  localparam int unsigned DW    = 10;
  localparam int unsigned RATIO = 4;
  localparam int unsigned WW    = DW * RATIO;

  logic          clk = 1'b0;
  logic          rstb;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          m_valid;
  logic [WW-1:0] m_data;
  logic [RATIO-1:0] m_keep;
  logic          m_last;
  logic          m_ready;

  int n_vec  = 0;
  int n_miss = 0;

  stream_upsizer #(.DW(DW), .RATIO(RATIO)) dut (
    .clk     (clk),
    .rstb    (rstb),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          sl;
    logic          mr;
    logic          e_sr;
    logic          e_mv;
    logic [WW-1:0] e_md;
    logic [3:0]    e_mk;
    logic          e_ml;
    bit            chk;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [WW-1:0] pk(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(input logic sv, input logic [DW-1:0] sd, input logic sl,
                              input logic mr, input logic e_sr, input logic e_mv,
                              input logic [WW-1:0] e_md, input logic [3:0] e_mk,
                              input logic e_ml, input bit chk);
    vec_t v;
    v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.e_sr = e_sr; v.e_mv = e_mv; v.e_md = e_md; v.e_mk = e_mk; v.e_ml = e_ml; v.chk = chk;
    return v;
  endfunction

  task automatic check(input string nm, input logic e_sr, input logic e_mv,
                       input logic [WW-1:0] e_md, input logic [3:0] e_mk,
                       input logic e_ml, input bit chk);
    bit bad = 0;
    n_vec++;
    if (s_ready !== e_sr) begin
      $display("FAIL %s s_ready got %b want %b", nm, s_ready, e_sr); bad = 1;
    end
    if (m_valid !== e_mv) begin
      $display("FAIL %s m_valid got %b want %b", nm, m_valid, e_mv); bad = 1;
    end
    if (chk) begin
      if (m_data !== e_md) begin
        $display("FAIL %s m_data got %h want %h", nm, m_data, e_md); bad = 1;
      end
      if (m_keep !== e_mk) begin
        $display("FAIL %s m_keep got %b want %b", nm, m_keep, e_mk); bad = 1;
      end
      if (m_last !== e_ml) begin
        $display("FAIL %s m_last got %b want %b", nm, m_last, e_ml); bad = 1;
      end
    end
    if (bad) n_miss++;
  endtask

  initial begin
    logic [WW-1:0] z;
    logic [WW-1:0] stall_w;
    int nw;
    bit sr_low;
    z = '0;
    stall_w = pk(10'h011, 10'h012, 10'h013, 10'h014);

    // Full word, partial flush, stall, first-beat flush, stray s_last, overlap.
    tbl.push_back(mk(1, 10'h001, 0, 1, 1, 0, z, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 10'h002, 0, 1, 1, 0, z, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 10'h003, 0, 1, 1, 0, z, 4'b0000, 0, 1));
    tbl.push_back(mk(1, 10'h004, 0, 1, 1, 0, z, 4'b0000, 0, 1));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h001, 10'h002, 10'h003, 10'h004), 4'b1111, 0, 1));
    tbl.push_back(mk(1, 10'h0A1, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h0A2, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h0A3, 1, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h0A1, 10'h0A2, 10'h0A3, 10'h000), 4'b0111, 1, 1));
    tbl.push_back(mk(1, 10'h011, 0, 0, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h012, 0, 0, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h013, 0, 0, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h014, 0, 0, 1, 0, z, 4'b0000, 0, 0));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk(1, 10'h055, 0, 0, 0, 1, stall_w, 4'b1111, 0, 1));
    tbl.push_back(mk(1, 10'h055, 0, 1, 1, 1, stall_w, 4'b1111, 0, 1));
    tbl.push_back(mk(1, 10'h056, 1, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h055, 10'h056, 10'h000, 10'h000), 4'b0011, 1, 1));
    tbl.push_back(mk(1, 10'h3FF, 1, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h3FF, 10'h000, 10'h000, 10'h000), 4'b0001, 1, 1));
    tbl.push_back(mk(0, 10'h000, 1, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h021, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h022, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h023, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h024, 0, 1, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h021, 10'h022, 10'h023, 10'h024), 4'b1111, 0, 1));
    tbl.push_back(mk(1, 10'h0AA, 1, 0, 1, 0, z, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 10'h0BB, 1, 1, 1, 1, pk(10'h0AA, 10'h000, 10'h000, 10'h000), 4'b0001, 1, 1));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 1, pk(10'h0BB, 10'h000, 10'h000, 10'h000), 4'b0001, 1, 1));
    tbl.push_back(mk(0, 10'h000, 0, 1, 1, 0, z, 4'b0000, 0, 0));

    rstb = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rstb = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      s_valid = tbl[i].sv; s_data = tbl[i].sd; s_last = tbl[i].sl; m_ready = tbl[i].mr;
      #1;
      check($sformatf("row%0d", i), tbl[i].e_sr, tbl[i].e_mv, tbl[i].e_md,
            tbl[i].e_mk, tbl[i].e_ml, tbl[i].chk);
    end

    // Sustained streaming: 16 beats must yield 4 words, s_ready never low.
    nw = 0; sr_low = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      m_ready = 1'b1; s_last = 1'b0;
      if (c < 16) begin s_valid = 1'b1; s_data = DW'(10'h100 + c); end
      else s_valid = 1'b0;
      #1;
      if (c < 16 && !s_ready) sr_low = 1;
      if (m_valid) begin
        check($sformatf("stream_word%0d", nw), 1'b1, 1'b1,
              pk(DW'(10'h100 + 4*nw), DW'(10'h101 + 4*nw), DW'(10'h102 + 4*nw), DW'(10'h103 + 4*nw)),
              4'b1111, 1'b0, 1);
        nw++;
      end
    end
    n_vec++;
    if (nw != 4 || sr_low) begin
      $display("FAIL stream_count words got %0d want 4, s_ready_dropped=%0d want 0", nw, sr_low);
      n_miss++;
    end

    // Reset mid-packet after two beats; no stale lanes afterward.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = DW'(10'h031 + c); s_last = 1'b0; m_ready = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1 rstb = 1'b0;
    #1 check("in_reset", 1'b1, 1'b0, z, 4'b0000, 1'b0, 1);
    @(negedge clk);
    rstb = 1'b1;
    #1 check("after_reset", 1'b1, 1'b0, z, 4'b0000, 1'b0, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = DW'(10'h041 + c);
      #1 check($sformatf("fresh_beat%0d", c), 1'b1, 1'b0, z, 4'b0000, 1'b0, 1);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1 check("fresh_word", 1'b1, 1'b1, pk(10'h041, 10'h042, 10'h043, 10'h044), 4'b1111, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
